// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_pkg
//  Purpose  : Shared definitions for the PS/2 scan-code set 2 keymap decoder.
//             This package holds the protocol byte constants, the parser
//             state encoding, the keymap entry width, the default keymap and
//             the byte-classification helpers.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    // Each keymap entry is {ext, code[7:0]}.
    localparam int KEY_ENTRY_W = 9;

    // Protocol bytes (scan-code set 2).
    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;
    localparam logic [7:0] PS2_BAT    = 8'hAA;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_OVF0   = 8'h00;
    localparam logic [7:0] PS2_OVF1   = 8'hFF;

    // The Pause key sends E1 followed by seven more bytes that carry no
    // meaning for the keymap.
    localparam logic [2:0] PS2_PAUSE_SKIP = 3'd7;

    // Parser states, explicitly encoded.
    typedef enum logic [2:0] {
        PS_IDLE     = 3'd0,
        PS_GOT_E0   = 3'd1,
        PS_GOT_F0   = 3'd2,
        PS_GOT_E0F0 = 3'd3,
        PS_SKIP_E1  = 3'd4
    } ps2_state_e;

    // Default keymap, entry 0 in the least significant bits:
    //   0 W, 1 S, 2 A, 3 D, 4 SPACE, 5 UP, 6 DOWN, 7 LEFT, 8 RIGHT, 9 ENTER
    localparam logic [10*KEY_ENTRY_W-1:0] PS2_DEFAULT_KEYMAP = {
        9'h05A,   // 9 ENTER
        9'h174,   // 8 RIGHT
        9'h16B,   // 7 LEFT
        9'h172,   // 6 DOWN
        9'h175,   // 5 UP
        9'h029,   // 4 SPACE
        9'h023,   // 3 D
        9'h01C,   // 2 A
        9'h01B,   // 1 S
        9'h01D    // 0 W
    };

    // Bytes that start a multi-byte sequence.
    function automatic logic ps2_is_prefix(input logic [7:0] b);
        return (b == PS2_EXT) || (b == PS2_BRK) || (b == PS2_PAUSE);
    endfunction

    // Controller responses and overrun codes that never reach the keymap.
    function automatic logic ps2_is_ignored(input logic [7:0] b);
        return (b == PS2_BAT)  || (b == PS2_ACK)  || (b == PS2_RESEND) ||
               (b == PS2_ECHO) || (b == PS2_OVF0) || (b == PS2_OVF1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_seq_parser.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_seq_parser
//  Purpose  : Scan-code set 2 sequence parser. It follows the E0/F0/E1
//             prefixes, drops the Pause sequence and times out stalled
//             prefixes. Its outputs are decoded combinationally from the
//             current byte, and the consumer registers them.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             i_clear         - synchronous return to IDLE
//             i_data/i_valid  - received byte and its one-cycle strobe
//             o_evt_valid     - a complete make/break ends on this byte
//             o_evt_break     - event is a break (release)
//             o_evt_ext       - event carried the E0 prefix
//             o_evt_code      - final scan-code byte of the event
//             o_err           - illegal sequence or prefix timeout
//  Revision : 1.0 - initial release
// ============================================================================
import ps2_pkg::*;

module ps2_seq_parser #(
    parameter int PREFIX_TIMEOUT = 1_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clear,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_evt_valid,
    output logic       o_evt_break,
    output logic       o_evt_ext,
    output logic [7:0] o_evt_code,
    output logic       o_err
);

    localparam int               CNT_W     = $clog2(PREFIX_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(PREFIX_TIMEOUT);

    ps2_state_e       r_state;
    ps2_state_e       w_state_nxt;
    ps2_state_e       w_cur;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       r_skip;
    logic [2:0]       w_skip_nxt;
    logic             w_timeout;
    logic             w_seq_err;

    always_comb begin
        // The timeout fires from the counter value alone, so a byte that
        // arrives in the same cycle is interpreted as if the parser were
        // already back in IDLE.
        w_timeout   = (r_state != PS_IDLE) && (r_cnt == c_TIMEOUT);
        w_cur       = w_timeout ? PS_IDLE : r_state;

        w_state_nxt = w_cur;
        w_skip_nxt  = (w_cur == PS_SKIP_E1) ? r_skip : 3'd0;
        w_seq_err   = 1'b0;
        o_evt_valid = 1'b0;
        o_evt_break = 1'b0;
        o_evt_ext   = 1'b0;
        o_evt_code  = i_data;

        if (i_valid) begin
            case (w_cur)
                PS_IDLE: begin
                    if (i_data == PS2_EXT) begin
                        w_state_nxt = PS_GOT_E0;
                    end else if (i_data == PS2_BRK) begin
                        w_state_nxt = PS_GOT_F0;
                    end else if (i_data == PS2_PAUSE) begin
                        w_state_nxt = PS_SKIP_E1;
                        w_skip_nxt  = PS2_PAUSE_SKIP;
                    end else if (!ps2_is_ignored(i_data)) begin
                        o_evt_valid = 1'b1;
                    end
                end
                PS_GOT_E0: begin
                    if (i_data == PS2_BRK) begin
                        w_state_nxt = PS_GOT_E0F0;
                    end else if (i_data != PS2_EXT) begin
                        // A repeated E0 keeps waiting; anything else is an
                        // extended make.
                        o_evt_valid = 1'b1;
                        o_evt_ext   = 1'b1;
                        w_state_nxt = PS_IDLE;
                    end
                end
                PS_GOT_F0, PS_GOT_E0F0: begin
                    w_state_nxt = PS_IDLE;
                    if (ps2_is_prefix(i_data)) begin
                        w_seq_err   = 1'b1;
                    end else begin
                        o_evt_valid = 1'b1;
                        o_evt_break = 1'b1;
                        o_evt_ext   = (w_cur == PS_GOT_E0F0);
                    end
                end
                PS_SKIP_E1: begin
                    w_skip_nxt = r_skip - 3'd1;
                    if (r_skip == 3'd1) begin
                        w_state_nxt = PS_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = PS_IDLE;
                end
            endcase
        end

        // The counter only runs while a sequence is open and the line is
        // idle; every byte restarts the window.
        if (w_timeout || i_valid || (r_state == PS_IDLE)) begin
            w_cnt_nxt = '0;
        end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end

        o_err = w_timeout | w_seq_err;
    end

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_state <= PS_IDLE;
            r_cnt   <= '0;
            r_skip  <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_skip  <= w_skip_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_keymap_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_keymap_decoder
//  Purpose  : PS/2 scan-code set 2 keymap decoder. It keeps one held bit
//             per mapped key and emits one-cycle press/release pulses.
//  Ports    : CLOCK_50       - system clock
//             reset          - synchronous, active-high
//             ps2_data       - received byte from the PS/2 controller
//             ps2_data_valid - one-cycle strobe for ps2_data
//             clear_all      - drop all held keys, parser back to IDLE
//             key_held       - level, key i is down
//             key_press      - pulse on the 0->1 transition of key_held[i]
//             key_release    - pulse on the 1->0 transition of key_held[i]
//             unmapped       - pulse, complete sequence matched no entry
//             proto_err      - pulse, illegal sequence or prefix timeout
//  Revision : 1.0 - initial release
// ============================================================================
import ps2_pkg::*;

module ps2_keymap_decoder #(
    parameter int                              NUM_KEYS       = 10,
    parameter logic [NUM_KEYS*KEY_ENTRY_W-1:0] KEY_MAP        = PS2_DEFAULT_KEYMAP,
    parameter int                              PREFIX_TIMEOUT = 1_500_000
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic [7:0]          ps2_data,
    input  logic                ps2_data_valid,
    input  logic                clear_all,
    output logic [NUM_KEYS-1:0] key_held,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic                unmapped,
    output logic                proto_err
);

    logic                w_evt_valid;
    logic                w_evt_break;
    logic                w_evt_ext;
    logic [7:0]          w_evt_code;
    logic                w_err;
    logic [NUM_KEYS-1:0] w_match;
    logic [NUM_KEYS-1:0] w_make_hits;
    logic [NUM_KEYS-1:0] w_brk_hits;

    logic [NUM_KEYS-1:0] r_held;
    logic [NUM_KEYS-1:0] r_press;
    logic [NUM_KEYS-1:0] r_release;
    logic                r_unmapped;
    logic                r_proto_err;

    ps2_seq_parser #(
        .PREFIX_TIMEOUT (PREFIX_TIMEOUT)
    ) u_parser (
        .clk         (CLOCK_50),
        .rst         (reset),
        .i_clear     (clear_all),
        .i_data      (ps2_data),
        .i_valid     (ps2_data_valid),
        .o_evt_valid (w_evt_valid),
        .o_evt_break (w_evt_break),
        .o_evt_ext   (w_evt_ext),
        .o_evt_code  (w_evt_code),
        .o_err       (w_err)
    );

    // Compare against every entry at once; duplicate entries all follow.
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_match
        assign w_match[gi] =
            (KEY_MAP[gi*KEY_ENTRY_W +: KEY_ENTRY_W] == {w_evt_ext, w_evt_code});
    end

    assign w_make_hits = (w_evt_valid && !w_evt_break) ? w_match : '0;
    assign w_brk_hits  = (w_evt_valid &&  w_evt_break) ? w_match : '0;

    always_ff @(posedge CLOCK_50) begin
        if (reset || clear_all) begin
            r_held      <= '0;
            r_press     <= '0;
            r_release   <= '0;
            r_unmapped  <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_held      <= (r_held | w_make_hits) & ~w_brk_hits;
            // Edges are taken against the previous held level, so typematic
            // repeats and breaks of released keys produce no pulse.
            r_press     <= w_make_hits & ~r_held;
            r_release   <= w_brk_hits  &  r_held;
            r_unmapped  <= w_evt_valid & ~(|w_match);
            r_proto_err <= w_err;
        end
    end

    assign key_held    = r_held;
    assign key_press   = r_press;
    assign key_release = r_release;
    assign unmapped    = r_unmapped;
    assign proto_err   = r_proto_err;

endmodule
`default_nettype wire

// File: doc/ps2_keymap_decoder.md
Name: ps2_keymap_decoder

Overview:
- Parametrised PS/2 scan-code set 2 decoder; consumes the received-byte stream from the PS/2 controller and keeps a held/not-held bit per mapped key.
- Tracks make, break (F0), extended (E0) and Pause (E1) sequences. Emits one-cycle press and release pulses, so game logic sees level and edge per key.
- Sits between the PS/2 controller and the tank control logic. Supports any number of players and keys through a packed keymap parameter.

Parameters:
- NUM_KEYS, 10, number of mapped keys; output bit i corresponds to keymap entry i.
- KEY_MAP, 90-bit default, packed 9-bit entries {ext, code[7:0]}; entry i occupies bits [9i+8:9i].
  - Default entries 0..9: W 0_1D, S 0_1B, A 0_1C, D 0_23, SPACE 0_29, UP 1_75, DOWN 1_72, LEFT 1_6B, RIGHT 1_74, ENTER 0_5A.
- PREFIX_TIMEOUT, 1_500_000, cycles (30 ms at 50 MHz) allowed between a prefix byte and its follow-up byte.

Ports:
- CLOCK_50  input  1  system clock, 50 MHz
- reset  input  1  synchronous, active-high
- ps2_data  input  8  received byte from the PS/2 controller
- ps2_data_valid  input  1  one-cycle strobe; ps2_data is valid while this is high
- clear_all  input  1  synchronous; drops all held keys and returns the parser to IDLE
- key_held  output  NUM_KEYS  level: key i is currently down
- key_press  output  NUM_KEYS  one-cycle pulse on the 0->1 transition of key_held[i]
- key_release  output  NUM_KEYS  one-cycle pulse on the 1->0 transition of key_held[i]
- unmapped  output  1  one-cycle pulse when a complete make/break sequence matches no entry
- proto_err  output  1  one-cycle pulse on an illegal sequence or a prefix timeout

Behaviour:
- Reset and clear_all:
  - All outputs are 0, parser state is IDLE, timeout and skip counters are 0.
  - clear_all produces no release pulses. reset takes priority over clear_all.
- Parser states: IDLE, GOT_E0, GOT_F0, GOT_E0F0, SKIP_E1. State advances only on cycles where ps2_data_valid is high.
- IDLE:
  - E0 -> GOT_E0; F0 -> GOT_F0; E1 -> SKIP_E1 with skip count 7.
  - AA, FA, FE, EE, 00, FF are ignored and stay IDLE.
  - Any other byte is a make with ext=0; stay IDLE.
- GOT_E0:
  - F0 -> GOT_E0F0.
  - E0 -> stay (repeated prefix is tolerated).
  - Any other byte is a make with ext=1 -> IDLE.
- GOT_F0:
  - Non-prefix byte is a break with ext=0 -> IDLE.
  - E0, F0 or E1 -> proto_err, IDLE, nothing applied.
- GOT_E0F0:
  - Non-prefix byte is a break with ext=1 -> IDLE.
  - Prefix byte -> proto_err, IDLE.
- SKIP_E1:
  - Each valid byte decrements the skip count; at 0 -> IDLE.
  - No key effects and no unmapped pulse for the Pause sequence.
- Timeout:
  - In GOT_E0, GOT_F0, GOT_E0F0 and SKIP_E1, a counter increments each cycle without a valid byte and clears on every valid byte.
  - When it reaches PREFIX_TIMEOUT: proto_err pulse, state IDLE, counter 0.
  - A valid byte in the same cycle as the timeout is processed from IDLE.
- Match:
  - {ext, byte} is compared against every KEY_MAP entry in parallel.
  - Every matching index is updated; duplicate entries are legal and all follow.
  - No match: unmapped pulse, no held change.
- Make: key_held[i] goes to 1. key_press[i] pulses only if key_held[i] was 0, so typematic repeats produce no pulse.
- Break: key_held[i] goes to 0. key_release[i] pulses only if key_held[i] was 1.
- Latency: the final byte's strobe in cycle N gives key_held, pulses, unmapped and proto_err in cycle N+1, all registered. Pulses last exactly one cycle.
- Keys are independent: a make or break of one key never alters another key's bit.

Decomposition:
- Shared package ps2_pkg:
  - Byte constants PS2_EXT=E0, PS2_BRK=F0, PS2_PAUSE=E1, PS2_BAT=AA, PS2_ACK=FA, PS2_RESEND=FE, PS2_ECHO=EE.
  - Parser state enum.
  - KEY_ENTRY_W=9.
- One sub-module, ps2_seq_parser: the state machine, timeout counter and E1 skip counter. It outputs a one-cycle event with {is_break, ext, code} plus proto_err.
- The top level holds the keymap compare and the held/pulse registers.

Test Plan:
- After reset, send 1D -> cycle N+1: key_held=0x001, key_press=0x001 for 1 cycle. Send 1D three more times -> no further key_press.
- Send F0 1D -> key_held=0x000, key_release=0x001 pulse. Send F0 1D again -> no release pulse.
- Send E0 75 -> key_held[5]=1 and key_press[5] pulses. Send bare 75 (keypad 8) -> unmapped pulse, key_held[5] stays 1. Send E0 F0 75 -> key_release[5] pulses.
- Send E1 14 77 E1 F0 14 F0 77 -> no key or unmapped activity, parser back in IDLE. Next 29 sets key_held[4].
- Send F0, then idle PREFIX_TIMEOUT cycles -> proto_err pulse. Then send 1B -> key_held[1]=1 (treated as make).
- Hold W and ENTER, assert clear_all -> key_held=0 with no release pulses. Send F0 E0 -> proto_err pulse.
